// File: rtl/riscv_defines_pkg.sv
// Shared types and constants for the end-of-test monitor.
package riscv_defines_pkg;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StPass,
    StFail,
    StTimeout
  } mon_state_e;

  localparam reg_idx_t REG_DONE_DEFAULT = 5'd26;
  localparam reg_idx_t REG_PASS_DEFAULT = 5'd27;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] cnt
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/riscv_test_monitor.sv
// Snoops regfile write-back, shadows x27..x29 and latches the test verdict or a timeout.
module riscv_test_monitor
  import riscv_defines_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter reg_idx_t    DONE_REG       = REG_DONE_DEFAULT,
  parameter reg_idx_t    PASS_REG       = REG_PASS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  output logic        test_done,
  output logic        test_pass,
  output logic        test_fail,
  output logic        test_timeout,
  output logic [31:0] x27_q,
  output logic [31:0] x28_q,
  output logic [31:0] x29_q,
  output logic [31:0] cycle_cnt,
  output logic [31:0] wr_cnt
);

  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

  mon_state_e  state_q, state_d;
  logic [31:0] verdict_q;
  logic        accept;
  logic        done_wr;
  logic        run;

  assign run     = (state_q == StRun);
  assign accept  = wb_we && (wb_waddr != 5'd0) && run;
  assign done_wr = accept && (wb_waddr == DONE_REG) && (wb_wdata == 32'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: state_d = StRun;
      StRun: begin
        // verdict_q is the pre-edge value, so a same-cycle verdict write does not count
        if (done_wr) begin
          state_d = (verdict_q == 32'd1) ? StPass : StFail;
        end else if (cycle_cnt == TimeoutLast) begin
          state_d = StTimeout;
        end
      end
      default: state_d = state_q;
    endcase
    if (clr) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      test_done    <= 1'b0;
      test_pass    <= 1'b0;
      test_fail    <= 1'b0;
      test_timeout <= 1'b0;
    end else begin
      state_q      <= state_d;
      test_done    <= (state_d == StPass) || (state_d == StFail) || (state_d == StTimeout);
      test_pass    <= (state_d == StPass);
      test_fail    <= (state_d == StFail);
      test_timeout <= (state_d == StTimeout);
    end
  end

  // Dedicated verdict shadow so PASS_REG need not be one of x27..x29
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x27_q     <= '0;
      x28_q     <= '0;
      x29_q     <= '0;
      verdict_q <= '0;
    end else if (clr) begin
      x27_q     <= '0;
      x28_q     <= '0;
      x29_q     <= '0;
      verdict_q <= '0;
    end else if (accept) begin
      if (wb_waddr == 5'd27) x27_q <= wb_wdata;
      if (wb_waddr == 5'd28) x28_q <= wb_wdata;
      if (wb_waddr == 5'd29) x29_q <= wb_wdata;
      if (wb_waddr == PASS_REG) verdict_q <= wb_wdata;
    end
  end

  sat_counter #(
    .Width (32)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (run),
    .cnt   (cycle_cnt)
  );

  sat_counter #(
    .Width (32)
  ) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (accept),
    .cnt   (wr_cnt)
  );

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor with a 20-cycle timeout.
module tb_riscv_test_monitor;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        test_done;
  logic        test_pass;
  logic        test_fail;
  logic        test_timeout;
  logic [31:0] x27_q;
  logic [31:0] x28_q;
  logic [31:0] x29_q;
  logic [31:0] cycle_cnt;
  logic [31:0] wr_cnt;

  int n_tests;
  int n_fail;

  riscv_test_monitor #(
    .TIMEOUT_CYCLES (20)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .wb_we        (wb_we),
    .wb_waddr     (wb_waddr),
    .wb_wdata     (wb_wdata),
    .test_done    (test_done),
    .test_pass    (test_pass),
    .test_fail    (test_fail),
    .test_timeout (test_timeout),
    .x27_q        (x27_q),
    .x28_q        (x28_q),
    .x29_q        (x29_q),
    .cycle_cnt    (cycle_cnt),
    .wr_cnt       (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    wb_we    = 1'b1;
    wb_waddr = addr;
    wb_wdata = data;
    step();
    wb_we    = 1'b0;
    wb_waddr = '0;
    wb_wdata = '0;
  endtask

  task automatic flags(input string tag, input logic [3:0] exp);
    check_eq(tag, {28'd0, test_done, test_pass, test_fail, test_timeout}, {28'd0, exp});
  endtask

  // Leaves the bench just after a posedge with rst_n released; the next edge is edge 1.
  task automatic do_reset();
    rst_n    = 1'b0;
    clr      = 1'b0;
    wb_we    = 1'b0;
    wb_waddr = '0;
    wb_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset values
    do_reset();
    flags("reset_flags", 4'b0000);
    check_eq("reset_x27", x27_q, 32'd0);
    check_eq("reset_cyc", cycle_cnt, 32'd0);
    check_eq("reset_wr", wr_cnt, 32'd0);

    // Pass path
    step();
    wr(5'd27, 32'd1);
    check_eq("pass_x27_latency", x27_q, 32'd1);
    flags("pass_before_done", 4'b0000);
    wr(5'd26, 32'd1);
    flags("pass_flags", 4'b1100);
    check_eq("pass_wr_cnt", wr_cnt, 32'd2);
    check_eq("pass_cyc", cycle_cnt, 32'd2);
    step();
    check_eq("pass_cyc_frozen", cycle_cnt, 32'd2);

    // Async reset while in PASS
    #2;
    rst_n = 1'b0;
    #1;
    flags("async_rst_flags", 4'b0000);
    check_eq("async_rst_x27", x27_q, 32'd0);

    // Fail path, then sticky
    do_reset();
    step();
    wr(5'd27, 32'd0);
    wr(5'd26, 32'd1);
    flags("fail_flags", 4'b1010);
    wr(5'd27, 32'd1);
    flags("fail_sticky", 4'b1010);
    check_eq("fail_x27_frozen", x27_q, 32'd0);
    check_eq("fail_wr_frozen", wr_cnt, 32'd2);

    // Timeout with no writes
    do_reset();
    repeat (20) step();
    flags("tmo_edge20", 4'b0000);
    check_eq("tmo_cyc_edge20", cycle_cnt, 32'd19);
    step();
    flags("tmo_edge21", 4'b1001);
    check_eq("tmo_cyc", cycle_cnt, 32'd20);
    step();
    check_eq("tmo_cyc_frozen", cycle_cnt, 32'd20);

    // Done write in the last RUN cycle beats timeout
    do_reset();
    step();
    wr(5'd27, 32'd1);
    repeat (18) step();
    check_eq("race_cyc19", cycle_cnt, 32'd19);
    wr(5'd26, 32'd1);
    flags("race_pass", 4'b1100);
    check_eq("race_cyc", cycle_cnt, 32'd20);

    // x0 ignored, non-1 done write only counts
    do_reset();
    step();
    wr(5'd0, 32'd5);
    wr(5'd26, 32'd2);
    step();
    flags("x0_flags", 4'b0000);
    check_eq("x0_wr_cnt", wr_cnt, 32'd1);
    check_eq("x0_x27", x27_q, 32'd0);
    check_eq("x0_x28", x28_q, 32'd0);
    check_eq("x0_x29", x29_q, 32'd0);

    // clr during RUN
    do_reset();
    step();
    wr(5'd28, 32'd7);
    wr(5'd29, 32'hDEAD_BEEF);
    check_eq("clr_pre_x28", x28_q, 32'd7);
    check_eq("clr_pre_x29", x29_q, 32'hDEAD_BEEF);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("clr_x28", x28_q, 32'd0);
    check_eq("clr_x29", x29_q, 32'd0);
    check_eq("clr_cyc", cycle_cnt, 32'd0);
    check_eq("clr_wr", wr_cnt, 32'd0);
    flags("clr_flags", 4'b0000);
    // Monitor is in IDLE here, so this write must be dropped
    wr(5'd27, 32'd1);
    check_eq("clr_idle_x27", x27_q, 32'd0);
    check_eq("clr_idle_wr", wr_cnt, 32'd0);
    wr(5'd27, 32'd1);
    check_eq("clr_run_x27", x27_q, 32'd1);
    check_eq("clr_run_wr", wr_cnt, 32'd1);
    check_eq("clr_run_cyc", cycle_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_test_monitor.md
# riscv_test_monitor

Synthesizable end-of-test monitor that sits directly downstream of the CPU register-file write-back port inside `riscv_soc`. It snoops every register write, keeps shadow copies of x27/x28/x29, detects the test-end handshake (x26 := 1, verdict in x27) and raises registered done/pass/fail/timeout flags. The harness and FPGA LEDs read these flags and shadows instead of probing regfile internals hierarchically.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 10000: cycles in RUN before declaring timeout; legal range 2 .. 2^32-1.
- `DONE_REG`, 26: register index whose write of 1 ends the test.
- `PASS_REG`, 27: register index holding the verdict; value 1 means pass.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `clr`  in  1  synchronous restart; returns the monitor to IDLE and zeroes all state.
- `wb_we`  in  1  regfile write enable, same cycle as the regfile write.
- `wb_waddr`  in  5  regfile write index.
- `wb_wdata`  in  32  regfile write data.
- `test_done`  out  1  test finished (pass, fail or timeout).
- `test_pass`  out  1  finished with pass.
- `test_fail`  out  1  finished with fail.
- `test_timeout`  out  1  RUN cycle limit reached.
- `x27_q`, `x28_q`, `x29_q`  out  32 each  shadow copies of x27/x28/x29.
- `cycle_cnt`  out  32  cycles spent in RUN, saturating.
- `wr_cnt`  out  32  accepted regfile writes in RUN, saturating.

## Operation
- States: IDLE, RUN, PASS, FAIL, TIMEOUT.
- IDLE → RUN unconditionally on the first clock edge after reset release or after `clr`.
- A write is accepted only when `wb_we`=1, `wb_waddr`≠0 and state=RUN. Writes to x0 are ignored entirely and do not count.
- An accepted write to 27/28/29 updates the matching shadow.
- An accepted write with `wb_waddr`=DONE_REG and `wb_wdata`=1 ends the test:
  - Go to PASS if the PASS_REG shadow equals 1, else FAIL.
  - The PASS_REG shadow value used is the one in place before this edge.
- `cycle_cnt` increments every RUN cycle. When it equals TIMEOUT_CYCLES-1 with no done write in that cycle, go to TIMEOUT.
- Simultaneous events, in priority order: reset > `clr` > done write > timeout.
- PASS, FAIL and TIMEOUT are sticky until `rst_n` or `clr`. In these states shadows and counters freeze and writes are ignored.
- Counters saturate at 32'hFFFF_FFFF; there is no wrap-around.
- Flag decode:
  - `test_done` = PASS|FAIL|TIMEOUT.
  - `test_pass`, `test_fail` and `test_timeout` are one-hot with their state.
- All outputs are registered.

## Timing
- Reset values: all outputs 0; state IDLE.
- Reset mid-test clears everything asynchronously. The first RUN cycle starts one edge after release.
- Shadow latency: one cycle. `x27_q` shows the new value in the cycle after the `wb_we` cycle.
- Verdict latency: one cycle. Flags are high in the cycle after the done write edge.
- Timeout: `test_timeout` rises exactly TIMEOUT_CYCLES+1 edges after reset release. This is 1 IDLE cycle plus TIMEOUT_CYCLES RUN cycles. At that point `cycle_cnt` = TIMEOUT_CYCLES.
- `clr`: takes effect on the edge where it is sampled high; outputs are 0 the following cycle.

## Structure
- The shared package `riscv_defines_pkg` holds:
  - the state enum `mon_state_e`;
  - the constants `REG_DONE_DEFAULT`=26, `REG_PASS_DEFAULT`=27;
  - the 5-bit register-index type.
- One sub-module, `sat_counter`: 32-bit, with `inc` and `clr` inputs, saturating. It is instantiated twice, for `cycle_cnt` and `wr_cnt`.
- The FSM, shadow registers and write-accept decode live in the top module.

## Test plan
- Pass path: write x27=1, then x26=1 → `test_pass`=1 and `test_done`=1 one cycle later; `x27_q`=1; `wr_cnt`=2.
- Fail path: write x27=0, then x26=1 → `test_fail`=1 and `test_pass`=0. A later write x27=1 leaves the flags and `x27_q` unchanged (sticky).
- Timeout: TIMEOUT_CYCLES=20, no writes → `test_timeout`=1 on edge 21 after reset release; `cycle_cnt`=20; `test_pass` and `test_fail` stay 0.
- Done beats timeout: TIMEOUT_CYCLES=20, x27=1 written earlier, x26=1 written in the cycle where `cycle_cnt`=19 → PASS, not TIMEOUT.
- x0 and non-1 done writes: write x0=5 and x26=2 → no flags, `wr_cnt` counts only the x26 write (=1), `x27_q`..`x29_q` stay 0.
- Reset and clr mid-test:
  - Assert `clr` during RUN with `x28_q`=7 → all outputs 0 the next cycle, then RUN resumes.
  - Assert `rst_n`=0 asynchronously in PASS → flags drop immediately, without waiting for a clock edge.
